// File: rtl/bus_slave_timer.sv
// Bus slave with a 32-bit interval timer and a level interrupt.
// Also the template responder for slow slaves: WAIT_CYCLES wait states before rdy_.
module bus_slave_timer #(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] WLOAD =
    CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] wcnt_nxt;
  logic             rw_q;
  logic [1:0]       addr_q;

  logic [1:0]       ctrl;
  logic             irq_q;
  logic [31:0]      expr;
  logic [31:0]      counter;

  logic             accept;
  logic             wr_en;
  logic             expire;
  logic             rd_rw;
  logic [1:0]       rd_addr;
  logic [31:0]      rd_sel;

  assign accept = (state == IDLE) && !cs_ && !as_;
  assign wr_en  = accept && !rw;
  assign expire = ctrl[0] && (counter == expr);
  assign irq    = irq_q;

  // With no wait states RESP is entered at the accept edge,
  // so the live request selects the read source there.
  assign rd_rw   = (state == IDLE) ? rw   : rw_q;
  assign rd_addr = (state == IDLE) ? addr : addr_q;

  always_comb begin
    rd_sel = '0;
    unique case (rd_addr)
      2'd0: rd_sel = {30'd0, ctrl};
      2'd1: rd_sel = {31'd0, irq_q};
      2'd2: rd_sel = expr;
      2'd3: rd_sel = counter;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            wcnt_nxt  = WLOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (wcnt == '0) state_nxt = RESP;
        else            wcnt_nxt  = wcnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wcnt    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      rdy_    <= 1'b1;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (accept) begin
        rw_q   <= rw;
        addr_q <= addr;
      end
      rdy_    <= (state_nxt != RESP);
      rd_data <= (state_nxt == RESP && rd_rw) ? rd_sel : '0;
    end
  end

  // Bus writes win over timer updates; expiry wins over a soft clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl    <= '0;
      irq_q   <= 1'b0;
      expr    <= '0;
      counter <= '0;
    end else begin
      if (wr_en && addr == 2'd0)    ctrl    <= wr_data[1:0];
      else if (expire && !ctrl[1])  ctrl[0] <= 1'b0;

      if (wr_en && addr == 2'd2)    expr    <= wr_data;

      if (wr_en && addr == 2'd3)    counter <= wr_data;
      else if (expire)              counter <= '0;
      else if (ctrl[0])             counter <= counter + 32'd1;

      if (expire)                   irq_q   <= 1'b1;
      else if (wr_en && addr == 2'd1 && !wr_data[0])
                                    irq_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_slave_timer.sv
// Directed bench for bus_slave_timer: register map, timer modes,
// event priorities, wait-state timing and reset mid-access.
module tb_bus_slave_timer;

  logic        clk;
  logic        reset;
  logic        cs0_;
  logic        cs3_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd0;
  logic [31:0] rd3;
  logic        rdy0_;
  logic        rdy3_;
  logic        irq0;
  logic        irq3;

  int n_chk  = 0;
  int n_fail = 0;

  bus_slave_timer #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .cs_(cs0_), .as_(as_),
    .rw(rw), .addr(addr), .wr_data(wr_data),
    .rd_data(rd0), .rdy_(rdy0_), .irq(irq0)
  );

  bus_slave_timer #(.WAIT_CYCLES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .reset(reset), .cs_(cs3_), .as_(as_),
    .rw(rw), .addr(addr), .wr_data(wr_data),
    .rd_data(rd3), .rdy_(rdy3_), .irq(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a posedge; returns just after the edge following RESP.
  // lat = edges after the accept edge at which rdy_ is first seen low.
  task automatic access(input bit sel3, input logic r, input logic [1:0] a,
                        input logic [31:0] d, output logic [31:0] q,
                        output int lat);
    rw = r; addr = a; wr_data = d; as_ = 1'b0;
    if (sel3) cs3_ = 1'b0;
    else      cs0_ = 1'b0;
    @(posedge clk); #1;
    as_ = 1'b1; cs0_ = 1'b1; cs3_ = 1'b1;
    lat = -1;
    q   = '0;
    for (int k = 0; k < 20; k++) begin
      if ((sel3 ? rdy3_ : rdy0_) == 1'b0) begin
        lat = k;
        q   = sel3 ? rd3 : rd0;
        break;
      end
      chk("rd_idle", sel3 ? rd3 : rd0, 32'd0);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("rdy_one_cycle", {31'd0, sel3 ? rdy3_ : rdy0_}, 32'd1);
    chk("rd_after", sel3 ? rd3 : rd0, 32'd0);
  endtask

  task automatic wr(input bit sel3, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    int          lat;
    access(sel3, 1'b0, a, d, q, lat);
    chk("wr_lat", lat, sel3 ? 32'd3 : 32'd0);
    chk("wr_rd", q, 32'd0);
  endtask

  task automatic rd(input bit sel3, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] q;
    int          lat;
    access(sel3, 1'b1, a, 32'd0, q, lat);
    chk("rd_lat", lat, sel3 ? 32'd3 : 32'd0);
    chk("rd_val", q, e);
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [12];
  logic [9:0]  pat;
  logic [31:0] q;
  int          lat;

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 32'h0000_0005, 32'h0};
    tbl[1]  = '{1'b1, 2'd2, 32'h0,         32'h0000_0005};
    tbl[2]  = '{1'b1, 2'd0, 32'h0,         32'h0};
    tbl[3]  = '{1'b1, 2'd1, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 2'd3, 32'h0,         32'h0};
    tbl[5]  = '{1'b0, 2'd3, 32'h0000_1234, 32'h0};
    tbl[6]  = '{1'b1, 2'd3, 32'h0,         32'h0000_1234};
    tbl[7]  = '{1'b0, 2'd0, 32'hFFFF_FFFC, 32'h0};
    tbl[8]  = '{1'b1, 2'd0, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 2'd2, 32'hDEAD_BEEF, 32'h0};
    tbl[10] = '{1'b1, 2'd2, 32'h0,         32'hDEAD_BEEF};
    tbl[11] = '{1'b0, 2'd3, 32'h0,         32'h0};

    reset = 1'b0; cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b1;
    rw = 1'b1; addr = '0; wr_data = '0;
    #12;
    chk("rst_rdy0", {31'd0, rdy0_}, 32'd1);
    chk("rst_rdy3", {31'd0, rdy3_}, 32'd1);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd3", rd3, 32'd0);
    chk("rst_irq0", {31'd0, irq0}, 32'd0);
    chk("rst_irq3", {31'd0, irq3}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      access(1'b0, tbl[i].r, tbl[i].a, tbl[i].d, q, lat);
      chk($sformatf("tbl%0d_lat", i), lat, 32'd0);
      chk($sformatf("tbl%0d_rd", i), q, tbl[i].exp);
    end

    // one-shot: counter 0..3, expiry on the fourth edge after start
    wr(0, 2'd2, 32'd3);
    wr(0, 2'd0, 32'd1);
    chk("os_irq_a", {31'd0, irq0}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("os_irq_b", {31'd0, irq0}, 32'd0);
    end
    @(posedge clk); #1;
    chk("os_irq_set", {31'd0, irq0}, 32'd1);
    rd(0, 2'd3, 32'd0);
    rd(0, 2'd0, 32'd0);
    rd(0, 2'd1, 32'd1);
    wr(0, 2'd1, 32'd1);
    chk("os_irq_hold", {31'd0, irq0}, 32'd1);
    wr(0, 2'd1, 32'd0);
    chk("os_irq_clr", {31'd0, irq0}, 32'd0);

    // periodic, expr=2: expiry at P+3, P+6, P+9
    wr(0, 2'd2, 32'd2);
    wr(0, 2'd0, 32'd3);
    chk("per_irq_a", {31'd0, irq0}, 32'd0);
    @(posedge clk); #1;
    chk("per_irq_b", {31'd0, irq0}, 32'd0);
    @(posedge clk); #1;
    chk("per_irq_1", {31'd0, irq0}, 32'd1);
    wr(0, 2'd1, 32'd0);
    chk("per_clr", {31'd0, irq0}, 32'd0);
    @(posedge clk); #1;
    chk("per_irq_2", {31'd0, irq0}, 32'd1);
    rd(0, 2'd0, 32'd3);
    wr(0, 2'd1, 32'd0);
    chk("clr_vs_expiry", {31'd0, irq0}, 32'd1);
    wr(0, 2'd3, 32'h10);
    rd(0, 2'd3, 32'h11);
    wr(0, 2'd0, 32'd0);

    // expr=0: irq re-sets every cycle, counter pinned at 0
    wr(0, 2'd1, 32'd0);
    chk("z_clr", {31'd0, irq0}, 32'd0);
    wr(0, 2'd3, 32'd0);
    wr(0, 2'd2, 32'd0);
    wr(0, 2'd0, 32'd3);
    chk("z_irq", {31'd0, irq0}, 32'd1);
    rd(0, 2'd3, 32'd0);
    wr(0, 2'd1, 32'd0);
    chk("z_irq_stuck", {31'd0, irq0}, 32'd1);
    wr(0, 2'd0, 32'd0);

    // three wait states
    wr(1, 2'd3, 32'h77);
    rd(1, 2'd3, 32'h77);

    // request held low throughout; a write shown during WAIT must be ignored
    rw = 1'b1; addr = 2'd3; wr_data = '0; as_ = 1'b0; cs3_ = 1'b0;
    @(posedge clk); #1;
    pat[0] = rdy3_;
    rw = 1'b0; addr = 2'd2; wr_data = 32'hBAD;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      pat[k] = rdy3_;
      if (k == 3) begin
        chk("w3_rd_cnt", rd3, 32'h77);
        rw = 1'b1;
      end
      if (k == 8) begin
        chk("w3_rd_expr", rd3, 32'd0);
        as_ = 1'b1; cs3_ = 1'b1;
      end
    end
    chk("w3_rdy_pattern", {22'd0, pat}, {22'd0, 10'b1011110111});

    // reset while in WAIT
    wr(1, 2'd3, 32'd0);
    wr(1, 2'd2, 32'd1);
    wr(1, 2'd0, 32'd3);
    chk("w3_irq_on", {31'd0, irq3}, 32'd1);
    rw = 1'b1; addr = 2'd2; as_ = 1'b0; cs3_ = 1'b0;
    @(posedge clk); #1;
    as_ = 1'b1; cs3_ = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'd0, rdy3_}, 32'd1);
    chk("mid_rst_irq", {31'd0, irq3}, 32'd0);
    chk("mid_rst_rd", rd3, 32'd0);
    #2 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("dropped_rdy", {31'd0, rdy3_}, 32'd1);
    end
    rd(1, 2'd2, 32'd0);
    rd(1, 2'd0, 32'd0);
    rd(1, 2'd3, 32'd0);
    rd(1, 2'd1, 32'd0);
    chk("post_rst_irq", {31'd0, irq3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
